// File: rtl/channel_pkg.sv
// Shared defaults and the stage record for channel_add_pipeline.
// Build option: define CHANNEL_ADD_SATURATE_EN to saturate each stage add.
package channel_pkg;
  localparam int          DEF_WIDTH  = 16;
  localparam int          DEF_STAGES = 4;
  localparam int unsigned DEF_INCR   = 2;

  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH-1:0] data;
  } stage_rec_t;
endpackage

// File: rtl/channel_add_stage.sv
// One pipeline register: loads upstream data + INCR when it advances.
// Build option: CHANNEL_ADD_SATURATE_EN clamps the add at all-ones instead of wrapping.
module channel_add_stage import channel_pkg::*; #(
  parameter type         rec_t = stage_rec_t,
  parameter int unsigned INCR  = DEF_INCR
) (
  input  logic clk,
  input  logic rst,
  input  logic i_adv,
  input  rec_t i_rec,
  output rec_t o_rec
);
  localparam int W = $bits(rec_t) - 1;

  rec_t         r_rec;
  logic [W-1:0] w_nxt;

`ifdef CHANNEL_ADD_SATURATE_EN
  logic [W:0] w_sum;
  assign w_sum = {1'b0, i_rec.data} + (W+1)'(INCR);
  assign w_nxt = w_sum[W] ? '1 : w_sum[W-1:0];
`else
  assign w_nxt = i_rec.data + W'(INCR);
`endif

  // A bubble moving in leaves the data untouched so the last result is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rec <= '0;
    end else if (i_adv) begin
      r_rec.vld <= i_rec.vld;
      if (i_rec.vld) r_rec.data <= w_nxt;
    end
  end

  assign o_rec = r_rec;
endmodule

// File: rtl/channel_add_pipeline.sv
// Elastic STAGES-deep pipeline adding INCR per stage, with valid/ready handshake.
// Build option: CHANNEL_ADD_SATURATE_EN selects saturating adds (see channel_add_stage).
module channel_add_pipeline import channel_pkg::*; #(
  parameter int          WIDTH  = DEF_WIDTH,
  parameter int          STAGES = DEF_STAGES,
  parameter int unsigned INCR   = DEF_INCR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);
  localparam int OW = $clog2(STAGES+1);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
  } rec_t;

  rec_t              w_in  [STAGES];
  rec_t              w_out [STAGES];
  logic [STAGES-1:0] w_vld;
  logic [STAGES:0]   w_adv;
  logic [OW-1:0]     w_occ;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_in[k] = '{vld: in_valid, data: in_data};
    end else begin : g_body
      assign w_in[k] = w_out[k-1];
    end

    channel_add_stage #(
      .rec_t (rec_t),
      .INCR  (INCR)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .i_adv (w_adv[k]),
      .i_rec (w_in[k]),
      .o_rec (w_out[k])
    );

    assign w_vld[k] = w_out[k].vld;
  end

  // Ready ripples back from the consumer; an empty stage always absorbs.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = !w_vld[STAGES-1] || out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      w_adv[k] = !w_vld[k] || w_adv[k+1];
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < STAGES; k++)
      w_occ = w_occ + OW'(w_vld[k]);
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_vld[STAGES-1];
  assign out_data  = w_out[STAGES-1].data;
  assign occupancy = w_occ;
endmodule

// File: tb/tb_channel_add_pipeline.sv
// Scoreboard bench: default pipeline (u_dut0) and a single-stage pipeline (u_dut1).
// Honours CHANNEL_ADD_SATURATE_EN for the wrap/saturate expectation.
module tb_channel_add_pipeline;
  typedef struct {
    logic [15:0] d;
    int          cyc;
    bit          lat;
  } exp_t;

`ifdef CHANNEL_ADD_SATURATE_EN
  localparam logic [15:0] FFFF_EXP = 16'hFFFF;
`else
  localparam logic [15:0] FFFF_EXP = 16'h0007;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data  [2];
  logic [2:0]  occ0;
  logic [0:0]  occ1;

  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  channel_add_pipeline u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occ0)
  );

  channel_add_pipeline #(.WIDTH(16), .STAGES(1), .INCR(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occ1)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitors: pop one expectation per observed output handshake.
  always @(negedge clk) begin
    if (rst && out_valid[0] && out_ready[0]) begin
      if (q0.size() == 0) begin
        tot_cnt++;
        $display("FAIL out0_unexpected: got %0h expected no output", out_data[0]);
      end else begin
        m0 = q0.pop_front();
        chk("out0_data", out_data[0], m0.d);
        if (m0.lat) chk("out0_latency", cyc - m0.cyc, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid[1] && out_ready[1]) begin
      if (q1.size() == 0) begin
        tot_cnt++;
        $display("FAIL out1_unexpected: got %0h expected no output", out_data[1]);
      end else begin
        m1 = q1.pop_front();
        chk("out1_data", out_data[1], m1.d);
        if (m1.lat) chk("out1_latency", cyc - m1.cyc, 0);
      end
    end
  end

  // Offer a word for up to max_wait cycles; on acceptance queue its expected result.
  task automatic send(input int sel, input logic [15:0] d, input logic [15:0] exp,
                      input int max_wait, input bit lat, output bit acc);
    exp_t e;
    in_valid[sel] = 1'b1;
    in_data[sel]  = d;
    acc = 1'b0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      if (in_ready[sel]) begin
        e = '{d: exp, cyc: cyc + 1, lat: lat};
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid[sel] = 1'b0;
  endtask

  task automatic wait_empty(input int sel, input int budget);
    int n;
    n = (sel == 0) ? q0.size() : q1.size();
    for (int i = 0; i < budget && n > 0; i++) begin
      @(negedge clk);
      n = (sel == 0) ? q0.size() : q1.size();
    end
    chk(sel == 0 ? "drain0_pending" : "drain1_pending", n, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit acc;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; in_data[s] = '0; out_ready[s] = 1'b1;
    end
    #1;
    chk("rst_out_valid0", out_valid[0], 0);
    chk("rst_out_data0",  out_data[0],  0);
    chk("rst_occ0",       occ0,         0);
    chk("rst_in_ready0",  in_ready[0],  1);
    chk("rst_out_valid1", out_valid[1], 0);
    chk("rst_occ1",       occ1,         0);
    #11 rst = 1'b1;
    @(posedge clk); #1;

    // Single stage: 10->12, 15->17, then idle holds 17 with out_valid low.
    send(1, 16'd10, 16'd12, 4, 1'b1, acc); chk("s1_acc_a", acc, 1);
    send(1, 16'd15, 16'd17, 4, 1'b1, acc); chk("s1_acc_b", acc, 1);
    in_data[1] = 16'd18;
    @(posedge clk); #1;
    @(negedge clk);
    chk("s1_hold_data",  out_data[1],  17);
    chk("s1_hold_valid", out_valid[1], 0);
    chk("s1_hold_occ",   occ1,         0);
    wait_empty(1, 10);

    // Back-to-back stream through four stages.
    send(0, 16'd10, 16'd18, 4, 1'b1, acc);
    send(0, 16'd11, 16'd19, 4, 1'b1, acc);
    send(0, 16'd12, 16'd20, 4, 1'b1, acc);
    wait_empty(0, 20);

    // Wrap / saturate boundary.
    send(0, 16'hFFFF, FFFF_EXP, 4, 1'b1, acc);
    send(0, 16'hFFF0, 16'hFFF8, 4, 1'b1, acc);
    wait_empty(0, 20);

    // Back-pressure: only four words fit, output held stable.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(0, 16'(20 + i), 16'(28 + i), (i < 4) ? 4 : 2, 1'b0, acc);
      chk("stall_accept", acc, (i < 4) ? 1 : 0);
    end
    @(negedge clk);
    chk("stall_occ",       occ0,         4);
    chk("stall_in_ready",  in_ready[0],  0);
    chk("stall_out_valid", out_valid[0], 1);
    chk("stall_out_data",  out_data[0],  28);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_empty(0, 20);

    // Mid-cycle reset with three words in flight.
    send(0, 16'd50, 16'd58, 4, 1'b1, acc);
    send(0, 16'd51, 16'd59, 4, 1'b1, acc);
    send(0, 16'd52, 16'd60, 4, 1'b1, acc);
    chk("pre_reset_occ", occ0, 3);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid[0], 0);
    chk("mid_rst_occ",       occ0,         0);
    chk("mid_rst_out_data",  out_data[0],  0);
    chk("mid_rst_in_ready",  in_ready[0],  1);
    q0.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    send(0, 16'd100, 16'd108, 4, 1'b1, acc);
    chk("post_rst_acc", acc, 1);
    wait_empty(0, 20);

    chk("final_q0", q0.size(), 0);
    chk("final_q1", q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
